// File: rtl/fb_pkg.sv
// Shared types and helpers for the filterbank tap sequencer slice.
package fb_pkg;

    // Default signed sample width used across the filterbank.
    localparam int FB_DW = 14;

    // Sequencer states: waiting for a sample, or walking the taps.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fb_seq_state_t;

    // Number of serial steps per sample: folded filters share one step per symmetric pair.
    function automatic int fb_steps(input int ntaps, input int fold);
        return (fold != 0) ? (ntaps + 1) / 2 : ntaps;
    endfunction

endpackage

// File: rtl/fb_delay_line.sv
// Shared sample delay line: tap 0 is the newest sample, tap NTAPS-1 the oldest.
module fb_delay_line
    import fb_pkg::*;
#(
    parameter int DW    = FB_DW,
    parameter int NTAPS = 119
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       shift_en,
    input  logic [DW-1:0]              din,
    output logic [NTAPS-1:0][DW-1:0]   taps
);

    // Shift in a new sample only when the sequencer accepts one; reset clears history.
    always_ff @(posedge clock) begin
        if (reset) begin
            taps <= '0;
        end else if (shift_en) begin
            taps <= {taps[NTAPS-2:0], din};
        end
    end

endmodule

// File: rtl/fb_tap_sequencer.sv
// Serial tap sequencer: accepts a sample, then broadcasts one (optionally pre-added) tap per cycle.
module fb_tap_sequencer
    import fb_pkg::*;
#(
    parameter  int DW    = FB_DW,
    parameter  int NTAPS = 119,
    parameter  int FOLD  = 1,
    localparam int STEPS = fb_steps(NTAPS, FOLD),
    localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clk_enable,
    input  logic [DW-1:0]   filter_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [DW:0]     tap_sum,
    output logic [IW-1:0]   tap_idx,
    output logic            tap_valid,
    output logic            tap_first,
    output logic            tap_last,
    output logic            busy
);

    localparam int            AW       = $clog2(NTAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(STEPS - 1);
    localparam logic [AW-1:0] TOP_IDX  = AW'(NTAPS - 1);
    localparam logic [AW-1:0] MID_IDX  = AW'((NTAPS - 1) / 2);
    localparam bit            HAS_MID  = (FOLD != 0) && ((NTAPS % 2) == 1);

    fb_seq_state_t            state;
    fb_seq_state_t            state_next;
    logic [IW-1:0]            cnt;
    logic [IW-1:0]            cnt_next;
    logic                     accept;
    logic                     load_tap;
    logic [NTAPS-1:0][DW-1:0] taps;
    logic [AW-1:0]            lo_idx;
    logic [AW-1:0]            hi_idx;
    logic [DW-1:0]            lo_tap;
    logic [DW-1:0]            hi_tap;
    logic [DW:0]              tap_calc;

    assign in_ready = (state == IDLE) && !reset;
    assign busy     = (state == RUN);
    assign accept   = clk_enable && in_valid && in_ready;

    fb_delay_line #(
        .DW    (DW),
        .NTAPS (NTAPS)
    ) u_delay_line (
        .clock    (clock),
        .reset    (reset),
        .shift_en (accept),
        .din      (filter_in),
        .taps     (taps)
    );

    // Pick the tap (and its mirror partner when folding) for the current step and pre-add at full width.
    always_comb begin
        lo_idx = AW'(cnt);
        hi_idx = TOP_IDX - lo_idx;
        lo_tap = taps[lo_idx];
        hi_tap = taps[hi_idx];
        if ((FOLD == 0) || (HAS_MID && (lo_idx == MID_IDX))) begin
            tap_calc = {lo_tap[DW-1], lo_tap};
        end else begin
            tap_calc = {lo_tap[DW-1], lo_tap} + {hi_tap[DW-1], hi_tap};
        end
    end

    // Next-state logic: one accepted sample starts a walk of STEPS taps, then back to waiting.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_tap   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                load_tap = 1'b1;
                cnt_next = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and step counter advance only on enabled cycles; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (clk_enable) begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Registered tap broadcast with framing flags; everything holds while disabled so MACs never double count.
    always_ff @(posedge clock) begin
        if (reset) begin
            tap_sum   <= '0;
            tap_idx   <= '0;
            tap_valid <= 1'b0;
            tap_first <= 1'b0;
            tap_last  <= 1'b0;
        end else if (clk_enable) begin
            tap_valid <= load_tap;
            tap_first <= load_tap && (cnt == '0);
            tap_last  <= load_tap && (cnt == LAST_IDX);
            if (load_tap) begin
                tap_sum <= tap_calc;
                tap_idx <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_fb_tap_sequencer.sv
// Directed bench for fb_tap_sequencer across folded, unfolded, minimal and default configurations.
module tb_fb_tap_sequencer;

    logic clock;
    logic reset;
    logic clk_enable;

    // Instance A: DW=14, NTAPS=5, FOLD=1 -> STEPS=3
    logic signed [13:0] a_filter_in;
    logic               a_in_valid;
    logic               a_in_ready;
    logic signed [14:0] a_tap_sum;
    logic [1:0]         a_tap_idx;
    logic               a_tap_valid, a_tap_first, a_tap_last, a_busy;

    // Instance B: NTAPS=4, FOLD=0 -> STEPS=4
    logic signed [13:0] b_filter_in;
    logic               b_in_valid;
    logic               b_in_ready;
    logic signed [14:0] b_tap_sum;
    logic [1:0]         b_tap_idx;
    logic               b_tap_valid, b_tap_first, b_tap_last, b_busy;

    // Instance C: defaults, NTAPS=119, FOLD=1 -> STEPS=60
    logic signed [13:0] c_filter_in;
    logic               c_in_valid;
    logic               c_in_ready;
    logic signed [14:0] c_tap_sum;
    logic [5:0]         c_tap_idx;
    logic               c_tap_valid, c_tap_first, c_tap_last, c_busy;

    // Instance D: NTAPS=2, FOLD=1 -> STEPS=1
    logic signed [13:0] d_filter_in;
    logic               d_in_valid;
    logic               d_in_ready;
    logic signed [14:0] d_tap_sum;
    logic [0:0]         d_tap_idx;
    logic               d_tap_valid, d_tap_first, d_tap_last, d_busy;

    int compare_count = 0;
    int fail_count    = 0;

    fb_tap_sequencer #(.DW(14), .NTAPS(5), .FOLD(1)) u_dut_a (
        .clock(clock), .reset(reset), .clk_enable(clk_enable),
        .filter_in(a_filter_in), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .tap_sum(a_tap_sum), .tap_idx(a_tap_idx), .tap_valid(a_tap_valid),
        .tap_first(a_tap_first), .tap_last(a_tap_last), .busy(a_busy)
    );

    fb_tap_sequencer #(.DW(14), .NTAPS(4), .FOLD(0)) u_dut_b (
        .clock(clock), .reset(reset), .clk_enable(clk_enable),
        .filter_in(b_filter_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .tap_sum(b_tap_sum), .tap_idx(b_tap_idx), .tap_valid(b_tap_valid),
        .tap_first(b_tap_first), .tap_last(b_tap_last), .busy(b_busy)
    );

    fb_tap_sequencer u_dut_c (
        .clock(clock), .reset(reset), .clk_enable(clk_enable),
        .filter_in(c_filter_in), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .tap_sum(c_tap_sum), .tap_idx(c_tap_idx), .tap_valid(c_tap_valid),
        .tap_first(c_tap_first), .tap_last(c_tap_last), .busy(c_busy)
    );

    fb_tap_sequencer #(.DW(14), .NTAPS(2), .FOLD(1)) u_dut_d (
        .clock(clock), .reset(reset), .clk_enable(clk_enable),
        .filter_in(d_filter_in), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .tap_sum(d_tap_sum), .tap_idx(d_tap_idx), .tap_valid(d_tap_valid),
        .tap_first(d_tap_first), .tap_last(d_tap_last), .busy(d_busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single comparison point: counts, asserts, reports.
    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One sample into instance A and its three-tap frame.
    task automatic apply_stimulus_a(input int sample, input int e0, input int e1, input int e2);
        int exp_sum [3];
        exp_sum = '{e0, e1, e2};
        a_filter_in = 14'(sample);
        a_in_valid  = 1'b1;
        tick();
        a_in_valid  = 1'b0;
        check_output("a_busy", a_busy, 1);
        for (int i = 0; i < 3; i++) begin
            check_output("a_ready_run", a_in_ready, 0);
            tick();
            check_output($sformatf("a_valid[%0d]", i), a_tap_valid, 1);
            check_output($sformatf("a_idx[%0d]", i), a_tap_idx, i);
            check_output($sformatf("a_sum[%0d]", i), a_tap_sum, exp_sum[i]);
            check_output($sformatf("a_first[%0d]", i), a_tap_first, (i == 0));
            check_output($sformatf("a_last[%0d]", i), a_tap_last, (i == 2));
        end
        check_output("a_ready_post", a_in_ready, 1);
    endtask

    // One sample into instance B and its four-tap frame; the frame plus accept spans five edges.
    task automatic apply_stimulus_b(input int sample, input int e0, input int e1, input int e2, input int e3);
        int exp_sum [4];
        exp_sum = '{e0, e1, e2, e3};
        b_filter_in = 14'(sample);
        b_in_valid  = 1'b1;
        tick();
        b_in_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("b_ready_run", b_in_ready, 0);
            tick();
            check_output($sformatf("b_valid[%0d]", i), b_tap_valid, 1);
            check_output($sformatf("b_idx[%0d]", i), b_tap_idx, i);
            check_output($sformatf("b_sum[%0d]", i), b_tap_sum, exp_sum[i]);
            check_output($sformatf("b_first[%0d]", i), b_tap_first, (i == 0));
            check_output($sformatf("b_last[%0d]", i), b_tap_last, (i == 3));
        end
        check_output("b_ready_post", b_in_ready, 1);
    endtask

    // One sample into instance D: single-step frame with first and last together.
    task automatic apply_stimulus_d(input int sample, input int e0);
        d_filter_in = 14'(sample);
        d_in_valid  = 1'b1;
        tick();
        d_in_valid  = 1'b0;
        check_output("d_busy", d_busy, 1);
        tick();
        check_output("d_valid", d_tap_valid, 1);
        check_output("d_idx", d_tap_idx, 0);
        check_output("d_sum", d_tap_sum, e0);
        check_output("d_first", d_tap_first, 1);
        check_output("d_last", d_tap_last, 1);
        check_output("d_ready_post", d_in_ready, 1);
        tick();
        check_output("d_valid_drop", d_tap_valid, 0);
    endtask

    // Directed sequence: reset, impulse, full-scale fold, unfolded, minimal, backpressure/enable, reset abort.
    initial begin
        int exp_idx;
        int last_idx;
        int frame_no;
        int n_acc;
        int acc_cyc [3];
        int exp_s;
        bit en_now;
        bit acc_now;

        reset       = 1'b1;
        clk_enable  = 1'b1;
        a_filter_in = '0; a_in_valid = 1'b0;
        b_filter_in = '0; b_in_valid = 1'b0;
        c_filter_in = '0; c_in_valid = 1'b0;
        d_filter_in = '0; d_in_valid = 1'b0;
        exp_idx = 0; last_idx = 0; frame_no = 0; n_acc = 0;
        acc_cyc = '{0, 0, 0};

        tick();
        tick();
        check_output("rst_c_valid", c_tap_valid, 0);
        check_output("rst_c_sum", c_tap_sum, 0);
        check_output("rst_c_idx", c_tap_idx, 0);
        check_output("rst_c_busy", c_busy, 0);
        check_output("rst_c_ready_in_reset", c_in_ready, 0);
        reset = 1'b0;
        #1;
        check_output("rst_c_ready", c_in_ready, 1);
        check_output("rst_a_ready", a_in_ready, 1);

        $display("[TB] impulse through NTAPS=5 folded line");
        apply_stimulus_a(100, 100, 0, 0);
        apply_stimulus_a(0, 0, 100, 0);
        apply_stimulus_a(0, 0, 0, 100);
        apply_stimulus_a(0, 0, 100, 0);
        apply_stimulus_a(0, 100, 0, 0);

        $display("[TB] full-scale negative fill");
        apply_stimulus_a(-8192, -8192, 0, 0);
        apply_stimulus_a(-8192, -8192, -8192, 0);
        apply_stimulus_a(-8192, -8192, -8192, -8192);
        apply_stimulus_a(-8192, -8192, -16384, -8192);
        apply_stimulus_a(-8192, -16384, -16384, -8192);

        $display("[TB] full-scale positive fill");
        apply_stimulus_a(8191, -1, -16384, -8192);
        apply_stimulus_a(8191, -1, -1, -8192);
        apply_stimulus_a(8191, -1, -1, 8191);
        apply_stimulus_a(8191, -1, 16382, 8191);
        apply_stimulus_a(8191, 16382, 16382, 8191);

        $display("[TB] unfolded NTAPS=4");
        apply_stimulus_b(1, 1, 0, 0, 0);
        apply_stimulus_b(2, 2, 1, 0, 0);
        apply_stimulus_b(3, 3, 2, 1, 0);
        apply_stimulus_b(4, 4, 3, 2, 1);

        $display("[TB] NTAPS=2 folded, single step");
        apply_stimulus_d(7, 7);
        apply_stimulus_d(-3, 4);

        $display("[TB] backpressure with enable gap on default instance");
        c_filter_in = 14'sd10;
        c_in_valid  = 1'b1;
        for (int n = 0; n < 400 && n_acc < 3; n++) begin
            en_now     = !(n >= 90 && n <= 92);
            clk_enable = en_now;
            acc_now    = en_now && c_in_valid && c_in_ready;
            tick();
            if (acc_now) begin
                acc_cyc[n_acc] = n;
                n_acc++;
                frame_no++;
                exp_idx = 0;
            end else if (en_now) begin
                if (frame_no == 1) exp_s = (exp_idx == 0) ? 10 : 0;
                else               exp_s = (exp_idx <= 1) ? 10 : 0;
                check_output("c_bp_valid", c_tap_valid, 1);
                check_output("c_bp_idx", c_tap_idx, exp_idx);
                check_output("c_bp_sum", c_tap_sum, exp_s);
                check_output("c_bp_first", c_tap_first, (exp_idx == 0));
                check_output("c_bp_last", c_tap_last, (exp_idx == 59));
                last_idx = exp_idx;
                exp_idx++;
            end else begin
                check_output("c_hold_valid", c_tap_valid, 1);
                check_output("c_hold_idx", c_tap_idx, last_idx);
            end
        end
        clk_enable = 1'b1;
        c_in_valid = 1'b0;
        check_output("c_accept_count", n_acc, 3);
        check_output("c_period_plain", acc_cyc[1] - acc_cyc[0], 61);
        check_output("c_period_stretched", acc_cyc[2] - acc_cyc[1], 64);

        $display("[TB] reset abort mid-frame");
        for (int i = 0; i < 31; i++) tick();
        check_output("c_pre_rst_idx", c_tap_idx, 30);
        check_output("c_pre_rst_valid", c_tap_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_output("c_rst_valid", c_tap_valid, 0);
        check_output("c_rst_sum", c_tap_sum, 0);
        check_output("c_rst_idx", c_tap_idx, 0);
        check_output("c_rst_first", c_tap_first, 0);
        check_output("c_rst_last", c_tap_last, 0);
        check_output("c_rst_busy", c_busy, 0);
        check_output("c_rst_ready", c_in_ready, 1);
        c_filter_in = 14'sd5;
        c_in_valid  = 1'b1;
        tick();
        c_in_valid  = 1'b0;
        tick();
        check_output("c_post_valid", c_tap_valid, 1);
        check_output("c_post_idx", c_tap_idx, 0);
        check_output("c_post_sum", c_tap_sum, 5);
        check_output("c_post_first", c_tap_first, 1);
        check_output("c_post_last", c_tap_last, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/fb_tap_sequencer.md
# fb_tap_sequencer

Parametrised shared delay line and serial tap sequencer for the nonuniform filterbank. It accepts input samples through a valid/ready handshake and shifts them into an NTAPS-deep delay line using a true clock enable, with no gated clock. After each accepted sample it walks the taps serially, optionally pre-adding symmetric pairs for linear-phase filters, and broadcasts one tap per cycle with framing flags to the per-band serial MAC filters.

## Interface
**Parameters**
- DW, 14: sample width, signed.
- NTAPS, 119: delay line depth. Must be 2 or more.
- FOLD, 1: 1 pre-adds symmetric tap pairs; 0 presents taps directly.
- STEPS, derived: (NTAPS+1)/2 when FOLD=1, otherwise NTAPS. Not overridable.
- IW, derived: $clog2(STEPS).

**Ports**
- clock, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high. Dominates clk_enable.
- clk_enable, input, 1: global enable. Every register holds when low.
- filter_in, input, DW: signed input sample.
- in_valid, input, 1: filter_in is valid.
- in_ready, output, 1: block can accept a sample.
- tap_sum, output, DW+1: signed tap value, either a pair sum or a sign-extended single tap.
- tap_idx, output, IW: coefficient index for tap_sum.
- tap_valid, output, 1: tap_sum and tap_idx are valid.
- tap_first, output, 1: marks tap_idx 0; MACs clear their accumulator.
- tap_last, output, 1: marks tap_idx STEPS-1; MACs register their result.
- busy, output, 1: high in state RUN.

## Operation
**Delay line**
- x[0] is the newest sample, x[NTAPS-1] the oldest.
- On accept: x[0] <= filter_in and x[k] <= x[k-1].
- The delay line changes only on accept.

**Accept rule**
- A sample is accepted on an edge where clk_enable, in_valid and in_ready are all high.
- in_ready = (state == IDLE) && !reset. It is combinational, with no dependency on in_valid.

**State machine (IDLE, RUN)**
- IDLE: on accept, shift the delay line, set cnt <= 0 and go to RUN.
- RUN: on each enabled edge:
  - register the tap output for cnt;
  - tap_valid <= 1;
  - tap_first <= (cnt == 0);
  - tap_last <= (cnt == STEPS-1);
  - cnt <= cnt + 1.
  - When cnt == STEPS-1, go to IDLE.
- IDLE on any edge with no new tap: tap_valid, tap_first and tap_last <= 0.

**Tap arithmetic**
- FOLD=1, k < NTAPS/2: tap_sum = sext(x[k]) + sext(x[NTAPS-1-k]).
- FOLD=1, NTAPS odd, k = (NTAPS-1)/2: tap_sum = sext(x[k]).
- FOLD=0: tap_sum = sext(x[k]).
- DW+1 bits is exact; no saturation or rounding.

**Disabled cycles and reset**
- clk_enable low: state, cnt, delay line and all outputs hold, including tap_valid. Downstream MACs share clk_enable, so a held tap is never counted twice.
- Reset:
  - delay line cleared to 0;
  - state IDLE, cnt 0;
  - tap_sum, tap_idx, tap_valid, tap_first and tap_last all 0.
- Reset during RUN aborts the frame: no tap_last is issued and the partial frame is discarded downstream.

## Timing
**Frame timing (accept at edge E0)**
- Taps for idx 0..STEPS-1 are visible after edges E1..E_STEPS.
- tap_first is high after E1; tap_last is high after E_STEPS.
- in_ready is high again after E_STEPS. The earliest next accept is edge E_STEPS+1.
- Sample period is STEPS+1 enabled cycles: 61 at the defaults.

**Ordering and corner cases**
- tap_valid is high on exactly STEPS consecutive enabled cycles per sample, in index order.
- A frame that coincides with disabled cycles is stretched by exactly those cycles, with no gaps in index order.
- FOLD=1 with even NTAPS has no middle tap; tap_last marks pair (NTAPS/2)-1.
- NTAPS=2 with FOLD=1 gives STEPS=1, so tap_first and tap_last are both high on the same cycle.
- in_valid high during RUN is ignored (in_ready is low); the source must hold the sample.

## Structure
- Package fb_pkg:
  - state enum fb_seq_state_t {IDLE, RUN};
  - function fb_steps(ntaps, fold), used to compute STEPS;
  - default sample width constant FB_DW = 14.
- Sub-module fb_delay_line (parameters DW, NTAPS):
  - inputs clock, reset, shift_en, din;
  - output: packed array of all taps.
- The top level holds the FSM, the counter, the pair-select mux and pre-adder, and the output registers.

## Test plan
- **Impulse, FOLD=1, NTAPS=5.** Accept 100, then accept 0 four times.
  - Frame 1: tap_sum 100, 0, 0.
  - Frame 5: 100, 0, 0.
  - Frames 2-4: 100 appears at idx 1 for frames 2 and 4, and at idx 2 for frame 3.
  - tap_first/tap_last framing is correct in every frame.
- **Full-scale fold, DW=14.** Fill the line with -8192, then check every pair.
  - Every pair gives tap_sum -16384 and the middle tap gives -8192, with no wrap.
  - Repeat with 8191: pairs give 16382.
- **FOLD=0, NTAPS=4.** Accept 1, 2, 3, 4.
  - The last frame gives tap_sum 4, 3, 2, 1 with idx 0-3.
  - Period is 5 cycles.
- **Backpressure and enable.** Hold in_valid high continuously; insert 3 clk_enable-low cycles mid-frame.
  - Accepts are spaced exactly STEPS+1 enabled cycles apart.
  - The frame stretches by 3 cycles.
  - No tap is skipped or duplicated.
- **Reset mid-RUN (defaults).** Assert reset at idx 30 for one cycle.
  - The next cycle shows all outputs 0, in_ready 1 and busy 0, with no tap_last.
  - Accepting 5 then gives frame idx 0 with tap_sum 5 (x[118] = 0).
